// File: rtl/lisnoc_packet_inject.sv
// Core-to-NoC packet injector: buffers {last, dest, data} words in a small FIFO
// and emits HEADER / PAYLOAD / LAST flits on a single virtual channel.
module lisnoc_packet_inject #(
  parameter int data_width = 32,
  parameter int destwidth  = 5,
  parameter int vchannels  = 1,
  parameter int vc_sel     = 0,
  parameter int fifo_depth = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [data_width-1:0] in_data,
  input  logic [destwidth-1:0]  in_dest,
  input  logic                  in_last,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [data_width+1:0] link_flit_o,
  output logic [vchannels-1:0]  link_valid_o,
  input  logic [vchannels-1:0]  link_ready_i
);

  localparam int AW = $clog2(fifo_depth);
  localparam logic [1:0] T_PLD  = 2'b00;
  localparam logic [1:0] T_HDR  = 2'b01;
  localparam logic [1:0] T_LAST = 2'b10;

  typedef struct packed {
    logic                  last;
    logic [destwidth-1:0]  dest;
    logic [data_width-1:0] data;
  } entry_t;

  typedef enum logic [1:0] {IDLE, HDR, BODY} state_t;

  entry_t                mem [fifo_depth];
  logic [AW:0]           wr_ptr, rd_ptr, fill;
  logic                  empty, full, push, pop;
  entry_t                head;

  state_t                state_q, state_d;
  logic [data_width+1:0] flit_q, flit_d, hdr_flit, body_flit;
  logic                  valid_q, valid_d;
  logic                  ready, slot_free, last_out;

  // ---------------------------------------------------------------- FIFO
  assign fill     = wr_ptr - rd_ptr;
  assign empty    = (fill == '0);
  assign full     = (fill == (AW+1)'(fifo_depth));
  assign in_ready = !full;
  assign push     = in_valid && !full;
  assign head     = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= '{last: in_last, dest: in_dest, data: in_data};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // ---------------------------------------------------------------- flit build
  always_comb begin
    hdr_flit = '0;
    hdr_flit[data_width+1 -: 2]        = T_HDR;
    hdr_flit[data_width-1 -: destwidth] = head.dest;
    body_flit = {(head.last ? T_LAST : T_PLD), head.data};
  end

  assign ready     = link_ready_i[vc_sel];
  assign slot_free = !valid_q || ready;
  // The register holding a LAST flit is what marks the end of the packet.
  assign last_out  = valid_q && (flit_q[data_width+1 -: 2] == T_LAST);

  // ---------------------------------------------------------------- FSM
  always_comb begin
    state_d = state_q;
    flit_d  = flit_q;
    valid_d = valid_q;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!empty) begin
          flit_d  = hdr_flit;
          valid_d = 1'b1;
          state_d = HDR;
        end
      end
      // Header's source entry stays in the FIFO until the header is taken.
      HDR: begin
        if (ready) begin
          flit_d  = body_flit;
          valid_d = 1'b1;
          pop     = 1'b1;
          state_d = BODY;
        end
      end
      BODY: begin
        if (slot_free) begin
          if (last_out) begin
            if (!empty) begin
              flit_d  = hdr_flit;
              valid_d = 1'b1;
              state_d = HDR;
            end else begin
              valid_d = 1'b0;
              state_d = IDLE;
            end
          end else if (!empty) begin
            flit_d  = body_flit;
            valid_d = 1'b1;
            pop     = 1'b1;
          end else begin
            valid_d = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      flit_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      flit_q  <= flit_d;
      valid_q <= valid_d;
    end
  end

  assign link_flit_o = flit_q;

  always_comb begin
    link_valid_o         = '0;
    link_valid_o[vc_sel] = valid_q;
  end

  logic unused_ready;
  assign unused_ready = ^link_ready_i;

endmodule

// File: tb/tb_lisnoc_packet_inject.sv
// Scoreboard bench for lisnoc_packet_inject on VC 1 of a two-VC link:
// stimulus pushes expected flits, a negedge monitor pops and compares.
module tb_lisnoc_packet_inject;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] in_data = '0;
  logic [4:0]  in_dest = '0;
  logic        in_last = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [33:0] link_flit_o;
  logic [1:0]  link_valid_o;
  logic [1:0]  link_ready_i = '0;

  lisnoc_packet_inject #(
    .data_width(32), .destwidth(5), .vchannels(2), .vc_sel(1), .fifo_depth(4)
  ) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_dest(in_dest), .in_last(in_last),
    .in_valid(in_valid), .in_ready(in_ready),
    .link_flit_o(link_flit_o), .link_valid_o(link_valid_o), .link_ready_i(link_ready_i)
  );

  always #5 clk = ~clk;

  int          vectors = 0;
  int          miscompares = 0;
  logic [33:0] exp_q[$];
  int          xfer_log[$];
  bit          in_pkt = 0;
  int          cyc = 0;
  logic [33:0] prev_flit = '0;
  bit          prev_hold = 0;
  bit          stop_rand = 0;

  function automatic void chk(input bit ok, input string name,
                              input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  // Packet-level reference: a header precedes the first word of each packet.
  function automatic void model_push(input logic [4:0] d, input logic [31:0] w, input logic l);
    if (!in_pkt) exp_q.push_back({2'b01, d, 27'b0});
    exp_q.push_back({(l ? 2'b10 : 2'b00), w});
    in_pkt = !l;
  endfunction

  function automatic logic [33:0] hdr(input logic [4:0] d);
    return {2'b01, d, 27'b0};
  endfunction

  task automatic set_rdy(input bit r);
    link_ready_i = {r, ~r};
  endtask

  // Called just after a posedge; returns just after the accepting posedge.
  task automatic push_word(input logic [4:0] d, input logic [31:0] w, input logic l);
    int n = 0;
    in_valid = 1'b1; in_dest = d; in_data = w; in_last = l;
    @(negedge clk);
    while (!in_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk(in_ready, "push_accept", 64'(in_ready), 64'd1);
    if (in_ready) model_push(d, w, l);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_dest = 5'($urandom);
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || link_valid_o[1]) && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk(exp_q.size() == 0 && !link_valid_o[1], "drain", 64'(exp_q.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  // Monitor: VC0 silence, hold-while-stalled, and flit content on each transfer.
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      prev_hold = 0;
    end else begin
      chk(!link_valid_o[0], "vc0_valid", 64'(link_valid_o), 64'd0);
      if (prev_hold)
        chk(link_valid_o[1] && link_flit_o == prev_flit, "hold_stable",
            64'({link_valid_o[1], link_flit_o}), 64'({1'b1, prev_flit}));
      if (link_valid_o[1] && link_ready_i[1]) begin
        xfer_log.push_back(cyc);
        if (exp_q.size() == 0) chk(1'b0, "unexpected_flit", 64'(link_flit_o), 64'd0);
        else begin
          logic [33:0] e;
          e = exp_q.pop_front();
          chk(link_flit_o == e, "flit", 64'(link_flit_o), 64'(e));
        end
      end
      prev_hold = link_valid_o[1] && !link_ready_i[1];
      prev_flit = link_flit_o;
    end
  end

  initial begin
    set_rdy(1'b0);
    #2 rst = 1'b1;
    #1;
    chk(link_valid_o == 2'b00 && link_flit_o == '0, "reset_outputs",
        64'({link_valid_o, link_flit_o}), 64'd0);
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    #1 chk(in_ready, "reset_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;

    // One-word packet: latency and exact flits.
    set_rdy(1'b1);
    push_word(5'h03, 32'hDEADBEEF, 1'b1);
    @(negedge clk) chk(!link_valid_o[1], "lat_pre", 64'(link_valid_o), 64'd0);
    @(negedge clk) chk(link_valid_o[1] && link_flit_o == hdr(5'h03), "lat_hdr",
                       64'(link_flit_o), 64'(hdr(5'h03)));
    @(negedge clk) chk(link_valid_o[1] && link_flit_o == {2'b10, 32'hDEADBEEF}, "lat_last",
                       64'(link_flit_o), 64'({2'b10, 32'hDEADBEEF}));
    @(negedge clk) chk(!link_valid_o[1], "idle_after", 64'(link_valid_o), 64'd0);
    @(posedge clk); #1;
    drain();

    // Three words with the header stalled for 5 cycles.
    set_rdy(1'b0);
    push_word(5'h09, 32'd1, 1'b0);
    push_word(5'h1F, 32'd2, 1'b0);
    push_word(5'h00, 32'd3, 1'b1);
    for (int i = 0; i < 5; i++)
      @(negedge clk) chk(link_valid_o[1] && link_flit_o == hdr(5'h09), "stall_hdr",
                         64'(link_flit_o), 64'(hdr(5'h09)));
    xfer_log.delete();
    @(posedge clk); #1 set_rdy(1'b1);
    drain();
    chk(xfer_log.size() == 4 && xfer_log[3] - xfer_log[0] == 3, "burst_3",
        64'(xfer_log.size()), 64'd4);

    // Fill the FIFO with the link stalled; one accepted flit frees a slot.
    set_rdy(1'b0);
    for (int i = 0; i < 4; i++) push_word(5'h04, 32'h100 + 32'(i), i == 3);
    @(negedge clk) chk(!in_ready, "full_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk); #1 set_rdy(1'b1);
    @(posedge clk); #1 set_rdy(1'b0);
    @(negedge clk) begin
      chk(in_ready, "pop_in_ready", 64'(in_ready), 64'd1);
      chk(link_valid_o[1] && link_flit_o[33:32] == 2'b00, "after_hdr_pld",
          64'(link_flit_o), 64'({2'b00, 32'h100}));
    end
    @(posedge clk); #1 set_rdy(1'b1);
    drain();

    // Back-to-back two-word packets.
    xfer_log.delete();
    push_word(5'h01, 32'hA1, 1'b0);
    push_word(5'h11, 32'hA2, 1'b1);
    push_word(5'h02, 32'hB1, 1'b0);
    push_word(5'h12, 32'hB2, 1'b1);
    drain();
    chk(xfer_log.size() == 6 && xfer_log[5] - xfer_log[0] == 5, "b2b_6",
        64'(xfer_log.size()), 64'd6);

    // Reset after the second payload of a four-word packet.
    for (int i = 0; i < 4; i++) push_word(5'h0B, 32'h200 + 32'(i), i == 3);
    @(posedge clk); #2 rst = 1'b1;
    #1 chk(link_valid_o == 2'b00 && link_flit_o == '0, "midpkt_reset",
           64'({link_valid_o, link_flit_o}), 64'd0);
    exp_q.delete();
    in_pkt = 0;
    @(posedge clk); #3 rst = 1'b0;
    #1 chk(in_ready, "post_reset_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    push_word(5'h07, 32'h7777, 1'b1);
    @(negedge clk);
    @(negedge clk) chk(link_valid_o[1] && link_flit_o == hdr(5'h07), "post_reset_hdr",
                       64'(link_flit_o), 64'(hdr(5'h07)));
    drain();

    // Random packets with random gaps and random link stalls.
    fork
      begin
        while (!stop_rand) begin
          @(posedge clk); #1;
          link_ready_i = {($urandom_range(0, 3) != 0), 1'($urandom)};
        end
      end
      begin
        for (int p = 0; p < 40; p++) begin
          int len;
          len = $urandom_range(1, 5);
          for (int w = 0; w < len; w++) begin
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            push_word(5'($urandom), $urandom, w == len - 1);
          end
        end
        stop_rand = 1;
      end
    join
    set_rdy(1'b1);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
